// File: rtl/mnist_pkg.sv
// Shared constants and types for the argmax classifier stage of the MNIST inference pipeline.
// Optional margin output is enabled with `define ARGMAX_MARGIN_EN.
package mnist_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int DATA_WIDTH  = 8;
    localparam int IDX_WIDTH   = 4;

    typedef logic signed [DATA_WIDTH-1:0] score_t;
    typedef logic [IDX_WIDTH-1:0]         idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } argmax_state_t;

    localparam idx_t   LAST_IDX  = idx_t'(NUM_CLASSES - 1);
    localparam score_t SCORE_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // Difference of two signed scores, widened by one bit so it cannot overflow.
    function automatic logic [DATA_WIDTH:0] score_diff(input score_t a, input score_t b);
        return {a[DATA_WIDTH-1], a} - {b[DATA_WIDTH-1], b};
    endfunction

endpackage

// File: rtl/argmax_update.sv
// Combinational compare/select: folds one (index, score) sample into the running best.
// With ARGMAX_MARGIN_EN the runner-up score is tracked alongside the best.
module argmax_update
    import mnist_pkg::*;
(
    input  logic   first,
    input  idx_t   cur_idx,
    input  score_t cur_score,
    input  idx_t   best_idx,
    input  score_t best_score,
`ifdef ARGMAX_MARGIN_EN
    input  score_t second_score,
    output score_t nxt_second_score,
`endif
    output idx_t   nxt_best_idx,
    output score_t nxt_best_score
);

    logic new_best;

    // Strictly greater: ties keep the lower index already held as best.
    assign new_best = first || (cur_score > best_score);

    always_comb begin
        nxt_best_idx   = best_idx;
        nxt_best_score = best_score;
        if (new_best) begin
            nxt_best_idx   = cur_idx;
            nxt_best_score = cur_score;
        end
    end

`ifdef ARGMAX_MARGIN_EN
    // A displaced best becomes the runner-up; a non-winning sample can still beat the runner-up.
    always_comb begin
        nxt_second_score = second_score;
        if (first) begin
            nxt_second_score = SCORE_MIN;
        end else if (cur_score > best_score) begin
            nxt_second_score = best_score;
        end else if (cur_score > second_score) begin
            nxt_second_score = cur_score;
        end
    end
`endif

endmodule

// File: rtl/argmax_classifier.sv
// Scans the network's output scores once per request and reports the index of the largest.
// Optional class_margin output (best minus runner-up) is enabled with `define ARGMAX_MARGIN_EN.
module argmax_classifier
    import mnist_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          dnn_done,
    output idx_t          score_idx,
    input  score_t        score,
    output logic          busy,
    output logic          class_valid,
    output idx_t          class_idx,
    output score_t        class_score,
`ifdef ARGMAX_MARGIN_EN
    output logic [DATA_WIDTH:0] class_margin,
`endif
    output argmax_state_t dbg_state
);

    // Handshake: a request is accepted when start && dnn_done in IDLE or DONE; busy is high
    // for exactly NUM_CLASSES cycles while scores are read, then class_valid rises and stays
    // high (holding class_idx/class_score) until the next accepted request or reset.

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0] state;
    idx_t       best_idx;
    score_t     best_score;
    idx_t       nxt_best_idx;
    score_t     nxt_best_score;
    logic       req;
    logic       first;
    logic       last;

`ifdef ARGMAX_MARGIN_EN
    score_t     second_score;
    score_t     nxt_second_score;
`endif

    assign req       = start && dnn_done;
    assign first     = (score_idx == '0);
    assign last      = (score_idx == LAST_IDX);
    assign dbg_state = argmax_state_t'(state);

    argmax_update u_update (
        .first            (first),
        .cur_idx          (score_idx),
        .cur_score        (score),
        .best_idx         (best_idx),
        .best_score       (best_score),
`ifdef ARGMAX_MARGIN_EN
        .second_score     (second_score),
        .nxt_second_score (nxt_second_score),
`endif
        .nxt_best_idx     (nxt_best_idx),
        .nxt_best_score   (nxt_best_score)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            score_idx   <= '0;
            busy        <= 1'b0;
            class_valid <= 1'b0;
            class_idx   <= '0;
            class_score <= '0;
            best_idx    <= '0;
            best_score  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        state     <= S_SCAN;
                        score_idx <= '0;
                        busy      <= 1'b1;
                    end
                end
                S_SCAN: begin
                    best_idx   <= nxt_best_idx;
                    best_score <= nxt_best_score;
                    if (last) begin
                        // Commit includes the final sample, so use the update outputs directly.
                        state       <= S_DONE;
                        score_idx   <= '0;
                        busy        <= 1'b0;
                        class_valid <= 1'b1;
                        class_idx   <= nxt_best_idx;
                        class_score <= nxt_best_score;
                    end else begin
                        score_idx <= score_idx + idx_t'(1);
                    end
                end
                S_DONE: begin
                    if (req) begin
                        state       <= S_SCAN;
                        score_idx   <= '0;
                        busy        <= 1'b1;
                        class_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    score_idx <= '0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARGMAX_MARGIN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            second_score <= '0;
            class_margin <= '0;
        end else if (state == S_SCAN) begin
            second_score <= nxt_second_score;
            if (last) begin
                class_margin <= score_diff(nxt_best_score, nxt_second_score);
            end
        end
    end
`endif

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed bench for argmax_classifier: a behavioural model checked every cycle plus literal pins.
module tb_argmax_classifier;
    import mnist_pkg::*;

    logic          clk;
    logic          rst;
    logic          start;
    logic          dnn_done;
    idx_t          score_idx;
    score_t        score;
    logic          busy;
    logic          class_valid;
    idx_t          class_idx;
    score_t        class_score;
    argmax_state_t dbg_state;
`ifdef ARGMAX_MARGIN_EN
    logic [DATA_WIDTH:0] class_margin;
`endif

    score_t scores [NUM_CLASSES];
    int     tests;
    int     failed;
    logic   chk_en;
    int     visits [16];

    assign score = (score_idx < idx_t'(NUM_CLASSES)) ? scores[score_idx] : score_t'(0);

    argmax_classifier dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .dnn_done     (dnn_done),
        .score_idx    (score_idx),
        .score        (score),
        .busy         (busy),
        .class_valid  (class_valid),
        .class_idx    (class_idx),
        .class_score  (class_score),
`ifdef ARGMAX_MARGIN_EN
        .class_margin (class_margin),
`endif
        .dbg_state    (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
        end
    endtask

    // Reference rules: first strictly-largest index, runner-up is the largest of the rest.
    function automatic int ref_idx();
        int b = 0;
        for (int i = 1; i < NUM_CLASSES; i++)
            if (scores[i] > scores[b]) b = i;
        return b;
    endfunction

    function automatic int ref_score();
        return int'(scores[ref_idx()]);
    endfunction

    function automatic int ref_margin();
        int b = ref_idx();
        int s = -1000;
        for (int i = 0; i < NUM_CLASSES; i++)
            if (i != b && int'(scores[i]) > s) s = int'(scores[i]);
        return int'(scores[b]) - s;
    endfunction

    // Behavioural model: 0 idle, 1 scanning (counting samples), 2 result held.
    int m_state, m_cnt, m_busy, m_valid, m_idx, m_score, m_margin;

    always @(posedge clk) begin
        if (rst) begin
            m_state <= 0; m_cnt <= 0; m_busy <= 0; m_valid <= 0;
            m_idx <= 0; m_score <= 0; m_margin <= 0;
        end else if (m_state == 1) begin
            if (m_cnt == NUM_CLASSES - 1) begin
                m_state <= 2; m_cnt <= 0; m_busy <= 0; m_valid <= 1;
                m_idx <= ref_idx(); m_score <= ref_score(); m_margin <= ref_margin();
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end else if (start && dnn_done) begin
            m_state <= 1; m_cnt <= 0; m_busy <= 1; m_valid <= 0;
        end
    end

    // Compare process
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_state", int'(dbg_state), m_state);
            check("cyc_busy", int'(busy), m_busy);
            check("cyc_valid", int'(class_valid), m_valid);
            check("cyc_score_idx", int'(score_idx), m_cnt);
            check("cyc_class_idx", int'(class_idx), m_idx);
            check("cyc_class_score", int'(class_score), m_score);
`ifdef ARGMAX_MARGIN_EN
            check("cyc_margin", int'(class_margin), m_margin);
`endif
        end
    end

    // Driver: one request, then count busy cycles (bounded) and record indices visited.
    task automatic run_scan(input string name, input int exp_idx, input int exp_score,
                            input int exp_margin, input bit mid_start);
        int n;
        for (int i = 0; i < 16; i++) visits[i] = 0;
        @(negedge clk);
        start = 1'b1;
        dnn_done = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 30) begin
            visits[score_idx]++;
            check({name, "_valid_low_while_busy"}, int'(class_valid), 0);
            n++;
            start = (mid_start && n == 3);
            @(negedge clk);
        end
        start = 1'b0;
        check({name, "_busy_cycles"}, n, NUM_CLASSES);
        check({name, "_valid"}, int'(class_valid), 1);
        check({name, "_class_idx"}, int'(class_idx), exp_idx);
        check({name, "_class_score"}, int'(class_score), exp_score);
`ifdef ARGMAX_MARGIN_EN
        check({name, "_margin"}, int'(class_margin), exp_margin);
`else
        if (exp_margin < 0) check({name, "_margin_arg"}, exp_margin, 0);
`endif
    endtask

    task automatic load(input int v0, input int v1, input int v2, input int v3, input int v4,
                        input int v5, input int v6, input int v7, input int v8, input int v9);
        scores[0] = score_t'(v0); scores[1] = score_t'(v1); scores[2] = score_t'(v2);
        scores[3] = score_t'(v3); scores[4] = score_t'(v4); scores[5] = score_t'(v5);
        scores[6] = score_t'(v6); scores[7] = score_t'(v7); scores[8] = score_t'(v8);
        scores[9] = score_t'(v9);
    endtask

    initial begin
        tests = 0;
        failed = 0;
        chk_en = 1'b0;
        rst = 1'b1;
        start = 1'b0;
        dnn_done = 1'b0;
        load(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset_state", int'(dbg_state), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_valid", int'(class_valid), 0);
        check("reset_class_score", int'(class_score), 0);
        rst = 1'b0;
        @(negedge clk);

        // Ramp: winner is the last index.
        load(10, 20, 30, 40, 50, 60, 70, 80, 90, 100);
        check("model_ramp_idx", ref_idx(), 9);
        check("model_ramp_margin", ref_margin(), 10);
        run_scan("ramp", 9, 100, 10, 1'b0);

        // Tie at the maximum keeps the lower index.
        load(5, -3, 127, 127, 0, 0, 0, 0, 0, 0);
        check("model_tie_idx", ref_idx(), 2);
        run_scan("tie", 2, 127, 0, 1'b0);

        // All most-negative scores; each index visited exactly once.
        load(-128, -128, -128, -128, -128, -128, -128, -128, -128, -128);
        run_scan("allmin", 0, -128, 0, 1'b0);
        for (int i = 0; i < 16; i++)
            check($sformatf("allmin_visit_%0d", i), visits[i], (i < NUM_CLASSES) ? 1 : 0);

        // Result retained when dnn_done falls; start without dnn_done is ignored.
        dnn_done = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        check("done_hold_valid", int'(class_valid), 1);
        check("done_hold_idx", int'(class_idx), 0);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        check("nodone_state", int'(dbg_state), 0);
        check("nodone_busy", int'(busy), 0);
        check("nodone_valid", int'(class_valid), 0);

        // Extra start mid-scan must not restart the scan.
        load(-5, 3, -20, 44, 1, 2, 43, -128, 0, 7);
        run_scan("midstart", 3, 44, 1, 1'b1);

        // Reset at scan cycle 5 discards the partial result.
        load(1, 2, 3, 4, 5, 6, 7, 8, 9, 10);
        @(negedge clk);
        start = 1'b1;
        dnn_done = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_state", int'(dbg_state), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_score_idx", int'(score_idx), 0);
        check("midrst_class_idx", int'(class_idx), 0);
        load(-1, -2, -3, -4, -5, -6, -7, -8, -9, -10);
        run_scan("after_rst", 0, -1, 1, 1'b0);

        // Restart from DONE with a new winner.
        load(0, 1, 2, 3, 4, 5, 6, 77, -60, 8);
        run_scan("win7", 7, 77, 69, 1'b0);
        load(0, 1, 2, 3, 99, 5, 6, 77, -60, 8);
        run_scan("win4", 4, 99, 22, 1'b0);

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
